// File: rtl/mole_pkg.sv
// Shared definitions for the mole animation sequencer: state encoding,
// sprite-select codes and the fixed hole position table.
package mole_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      ASCEND     = 3'd1,
      UP         = 3'd2,
      DESC_DEAD  = 3'd3,
      DESC_HAPPY = 3'd4
   } mole_state_t;

   localparam logic [1:0] SEL_NONE   = 2'd0;
   localparam logic [1:0] SEL_NORMAL = 2'd1;
   localparam logic [1:0] SEL_HAPPY  = 2'd2;
   localparam logic [1:0] SEL_DEAD   = 2'd3;

   // Hole table, indexed by hole number 0..7 (element 7 is leftmost).
   localparam logic [7:0][10:0] HOLE_X = {
      11'd747, 11'd406, 11'd65,  11'd747,
      11'd65,  11'd747, 11'd406, 11'd65
   };
   localparam logic [7:0][9:0] HOLE_YBASE = {
      10'd512, 10'd512, 10'd512, 10'd256,
      10'd256, 10'd0,   10'd0,   10'd0
   };

endpackage

// File: rtl/mole_anim_sequencer_fifo.sv
// Request queue for mole spawns: synchronous FIFO of 3-bit hole indices.
// Full flag is registered alongside the count so req_ready is glitch-free.
module mole_req_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                         vclock,
   input  logic                         i_reset,
   input  logic                         i_push,
   input  logic [2:0]                   i_push_data,
   input  logic                         i_pop,
   output logic [2:0]                   o_pop_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [2:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_full;

   logic          w_push;
   logic          w_pop;
   logic [CW-1:0] w_count_nxt;

   assign w_push = i_push & ~r_full;
   assign w_pop  = i_pop & (r_count != '0);

   // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push & ~w_pop) begin
         w_count_nxt = r_count + CW'(1);
      end else if (w_pop & ~w_push) begin
         w_count_nxt = r_count - CW'(1);
      end
   end

   // Pointers, count and registered full flag.
   always_ff @(posedge vclock) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
      end
   end

   // Entry storage; contents need no reset since the pointers gate them.
   always_ff @(posedge vclock) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_pop_data = r_mem[r_rd_ptr];
   assign o_full     = r_full;
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;

endmodule

// File: rtl/mole_anim_sequencer.sv
// Mole life-cycle sequencer: pops queued spawn requests, animates the
// sprite up, holds it, then animates it back down as dead or happy,
// reporting hit/miss to the game FSM as single-cycle pulses.
// Build option: MOLE_STOMP_IN_ASCENT_EN lets a matching stomp whack a
// mole that is still rising.
//
// state      | meaning
// IDLE       | no mole shown; pop next request if queued
// ASCEND     | sprite rising one line per step tick
// UP         | fully raised; waiting for stomp or hold expiry
// DESC_DEAD  | whacked; sprite sinking with dead face
// DESC_HAPPY | missed; sprite sinking with happy face
module mole_anim_sequencer
   import mole_pkg::*;
#(
   parameter int STEP_DIV   = 33750,
   parameter int SPRITE_H   = 256,
   parameter int UP_TICKS   = 1024,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        vclock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_loc,
   output logic        req_ready,
   input  logic        stomp,
   input  logic [2:0]  stomp_loc,
   output logic [10:0] mole_x,
   output logic [9:0]  mole_ybase,
   output logic [9:0]  mole_ytop,
   output logic [1:0]  sprite_sel,
   output logic        hit_pulse,
   output logic        miss_pulse,
   output logic        busy
);

   localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int HW = (UP_TICKS > 1) ? $clog2(UP_TICKS) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(UP_TICKS - 1);
   localparam logic [8:0]    OFF_MAX   = 9'(SPRITE_H - 1);

   mole_state_t   r_state;
   mole_state_t   w_state_nxt;
   logic [SW-1:0] r_step_cnt;
   logic [8:0]    r_offset;
   logic [8:0]    w_offset_nxt;
   logic [HW-1:0] r_hold;
   logic [HW-1:0] w_hold_nxt;
   logic [2:0]    r_loc;
   logic [2:0]    w_loc_nxt;
   logic [10:0]   r_x;
   logic [10:0]   w_x_nxt;
   logic [9:0]    r_ybase;
   logic [9:0]    w_ybase_nxt;
   logic          r_hit;
   logic          w_hit_nxt;
   logic          r_miss;
   logic          w_miss_nxt;
   logic [1:0]    w_sel;

   logic          w_tick;
   logic          w_stomp_match;
   logic          w_fifo_push;
   logic          w_fifo_pop;
   logic [2:0]    w_fifo_data;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic [CW-1:0] w_fifo_count;

   assign w_tick        = (r_step_cnt == STEP_LAST);
   assign w_stomp_match = stomp & (stomp_loc == r_loc);
   assign w_fifo_push   = req_valid & req_ready;

   mole_req_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .vclock      (vclock),
      .i_reset     (reset),
      .i_push      (w_fifo_push),
      .i_push_data (req_loc),
      .i_pop       (w_fifo_pop),
      .o_pop_data  (w_fifo_data),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   // Free-running animation step divider.
   always_ff @(posedge vclock) begin
      if (reset) begin
         r_step_cnt <= '0;
      end else if (w_tick) begin
         r_step_cnt <= '0;
      end else begin
         r_step_cnt <= r_step_cnt + SW'(1);
      end
   end

   // Next-state, animation arithmetic and pulse generation.
   always_comb begin
      w_state_nxt  = r_state;
      w_offset_nxt = r_offset;
      w_hold_nxt   = r_hold;
      w_loc_nxt    = r_loc;
      w_x_nxt      = r_x;
      w_ybase_nxt  = r_ybase;
      w_hit_nxt    = 1'b0;
      w_miss_nxt   = 1'b0;
      w_fifo_pop   = 1'b0;
      w_sel        = SEL_NONE;
      case (r_state)
         IDLE: begin
            if (!w_fifo_empty) begin
               w_fifo_pop   = 1'b1;
               w_loc_nxt    = w_fifo_data;
               w_x_nxt      = HOLE_X[w_fifo_data];
               w_ybase_nxt  = HOLE_YBASE[w_fifo_data];
               w_offset_nxt = OFF_MAX;
               w_state_nxt  = ASCEND;
            end
         end
         ASCEND: begin
            w_sel = SEL_NORMAL;
`ifdef MOLE_STOMP_IN_ASCENT_EN
            if (w_stomp_match) begin
               w_hit_nxt   = 1'b1;
               w_state_nxt = DESC_DEAD;
            end else
`endif
            if (w_tick) begin
               w_offset_nxt = r_offset - 9'd1;
               if (w_offset_nxt == 9'd0) begin
                  w_state_nxt = UP;
                  w_hold_nxt  = '0;
               end
            end
         end
         UP: begin
            w_sel = SEL_NORMAL;
            // Stomp takes priority over an expiry tick in the same cycle.
            if (w_stomp_match) begin
               w_hit_nxt   = 1'b1;
               w_state_nxt = DESC_DEAD;
            end else if (w_tick) begin
               if (r_hold == HOLD_LAST) begin
                  w_miss_nxt  = 1'b1;
                  w_state_nxt = DESC_HAPPY;
               end else begin
                  w_hold_nxt = r_hold + HW'(1);
               end
            end
         end
         DESC_DEAD, DESC_HAPPY: begin
            w_sel = (r_state == DESC_DEAD) ? SEL_DEAD : SEL_HAPPY;
            // Saturate at the bottom; an ascent whack at full depth
            // simply finishes on the next tick.
            if (w_tick) begin
               if (r_offset >= OFF_MAX - 9'd1) begin
                  w_offset_nxt = OFF_MAX;
                  w_state_nxt  = IDLE;
               end else begin
                  w_offset_nxt = r_offset + 9'd1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge vclock) begin
      if (reset) begin
         r_state  <= IDLE;
         r_offset <= OFF_MAX;
         r_hold   <= '0;
         r_loc    <= 3'd0;
         r_x      <= HOLE_X[0];
         r_ybase  <= HOLE_YBASE[0];
         r_hit    <= 1'b0;
         r_miss   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_offset <= w_offset_nxt;
         r_hold   <= w_hold_nxt;
         r_loc    <= w_loc_nxt;
         r_x      <= w_x_nxt;
         r_ybase  <= w_ybase_nxt;
         r_hit    <= w_hit_nxt;
         r_miss   <= w_miss_nxt;
      end
   end

   assign req_ready  = ~w_fifo_full;
   assign mole_x     = r_x;
   assign mole_ybase = r_ybase;
   assign mole_ytop  = r_ybase + {1'b0, r_offset};
   assign sprite_sel = w_sel;
   assign hit_pulse  = r_hit;
   assign miss_pulse = r_miss;
   assign busy       = (r_state != IDLE) | (w_fifo_count != '0);

endmodule

// File: tb/tb_mole_anim_sequencer.sv
// Directed bench for mole_anim_sequencer with STEP_DIV=4, UP_TICKS=8,
// SPRITE_H=256. Define MOLE_STOMP_IN_ASCENT_EN for both bench and RTL to
// exercise the ascent-whack build.
module tb_mole_anim_sequencer;

   logic        vclock;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_loc;
   logic        req_ready;
   logic        stomp;
   logic [2:0]  stomp_loc;
   logic [10:0] mole_x;
   logic [9:0]  mole_ybase;
   logic [9:0]  mole_ytop;
   logic [1:0]  sprite_sel;
   logic        hit_pulse;
   logic        miss_pulse;
   logic        busy;

   int n_total;
   int n_bad;

   mole_anim_sequencer #(
      .STEP_DIV   (4),
      .SPRITE_H   (256),
      .UP_TICKS   (8),
      .FIFO_DEPTH (4)
   ) dut (
      .vclock     (vclock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_loc    (req_loc),
      .req_ready  (req_ready),
      .stomp      (stomp),
      .stomp_loc  (stomp_loc),
      .mole_x     (mole_x),
      .mole_ybase (mole_ybase),
      .mole_ytop  (mole_ytop),
      .sprite_sel (sprite_sel),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .busy       (busy)
   );

   initial vclock = 1'b0;
   always #5 vclock = ~vclock;

   task automatic step();
      @(posedge vclock);
      #1;
   endtask

   task automatic wait_sel(input logic [1:0] want, input int budget, output int cyc,
                           output bit ok, output bit saw_hit, output bit saw_miss);
      cyc = 0; saw_hit = 0; saw_miss = 0;
      ok = (sprite_sel == want);
      while (!ok && cyc < budget) begin
         step(); cyc++;
         if (hit_pulse)  saw_hit  = 1;
         if (miss_pulse) saw_miss = 1;
         ok = (sprite_sel == want);
      end
   endtask

   task automatic wait_up(input int budget, output bit ok);
      int cyc;
      cyc = 0;
      ok = (sprite_sel == 2'd1) && (mole_ytop == mole_ybase);
      while (!ok && cyc < budget) begin
         step(); cyc++;
         ok = (sprite_sel == 2'd1) && (mole_ytop == mole_ybase);
      end
   endtask

   task automatic spawn(input logic [2:0] loc);
      req_valid = 1'b1; req_loc = loc;
      step();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; req_loc = 3'd0; stomp = 1'b0; stomp_loc = 3'd0;
      repeat (3) step();
      n_total++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready got=%0d exp=1", req_ready); end
      n_total++; if (sprite_sel !== 2'd0) begin n_bad++; $display("FAIL rst_sel got=%0d exp=0", sprite_sel); end
      n_total++; if ({hit_pulse, miss_pulse} !== 2'b00) begin n_bad++; $display("FAIL rst_pulses got=%b exp=00", {hit_pulse, miss_pulse}); end
      n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%0d exp=0", busy); end
      n_total++; if (mole_x !== 11'd65) begin n_bad++; $display("FAIL rst_x got=%0d exp=65", mole_x); end
      n_total++; if (mole_ybase !== 10'd0) begin n_bad++; $display("FAIL rst_ybase got=%0d exp=0", mole_ybase); end
      n_total++; if (mole_ytop !== 10'd255) begin n_bad++; $display("FAIL rst_ytop got=%0d exp=255", mole_ytop); end
      reset = 1'b0;
      step();
   endtask

   task automatic test_spawn();
      int prev, steps, since, cyc;
      bit bad_step;
      spawn(3'd6);
      n_total++; if (sprite_sel !== 2'd0) begin n_bad++; $display("FAIL spawn_n_sel got=%0d exp=0", sprite_sel); end
      n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL spawn_n_busy got=%0d exp=1", busy); end
      step();
      n_total++; if (sprite_sel !== 2'd1) begin n_bad++; $display("FAIL spawn_sel got=%0d exp=1", sprite_sel); end
      n_total++; if (mole_x !== 11'd406) begin n_bad++; $display("FAIL spawn_x got=%0d exp=406", mole_x); end
      n_total++; if (mole_ybase !== 10'd512) begin n_bad++; $display("FAIL spawn_ybase got=%0d exp=512", mole_ybase); end
      n_total++; if (mole_ytop !== 10'd767) begin n_bad++; $display("FAIL spawn_ytop got=%0d exp=767", mole_ytop); end
      prev = 767; steps = 0; since = 0; cyc = 0; bad_step = 0;
      while (mole_ytop != 10'd512 && cyc < 1040) begin
         step(); cyc++; since++;
         if (int'(mole_ytop) != prev) begin
            if (int'(mole_ytop) != prev - 1) bad_step = 1;
            if (steps > 0 && since != 4) bad_step = 1;
            if (steps == 0 && since > 4) bad_step = 1;
            steps++; since = 0; prev = int'(mole_ytop);
         end
      end
      n_total++; if (mole_ytop !== 10'd512) begin n_bad++; $display("FAIL ascent_timeout ytop=%0d exp=512", mole_ytop); end
      n_total++; if (steps != 255) begin n_bad++; $display("FAIL ascent_ticks got=%0d exp=255", steps); end
      n_total++; if (bad_step) begin n_bad++; $display("FAIL ascent_cadence got=irregular exp=one line per 4 cycles"); end
      n_total++; if (sprite_sel !== 2'd1) begin n_bad++; $display("FAIL up_sel got=%0d exp=1", sprite_sel); end
   endtask

   task automatic test_miss();
      int cyc;
      bit ok, sh, sm, early_hit;
      cyc = 0; early_hit = 0;
      while (!miss_pulse && cyc < 40) begin
         step(); cyc++;
         if (hit_pulse) early_hit = 1;
      end
      n_total++; if (cyc != 32) begin n_bad++; $display("FAIL miss_latency got=%0d exp=32", cyc); end
      n_total++; if (sprite_sel !== 2'd2) begin n_bad++; $display("FAIL miss_sel got=%0d exp=2", sprite_sel); end
      n_total++; if (early_hit) begin n_bad++; $display("FAIL miss_spurious_hit got=1 exp=0"); end
      step();
      n_total++; if (miss_pulse !== 1'b0) begin n_bad++; $display("FAIL miss_width got=%0d exp=0", miss_pulse); end
      wait_sel(2'd0, 1100, cyc, ok, sh, sm);
      n_total++; if (cyc + 1 != 1020) begin n_bad++; $display("FAIL happy_descent_cycles got=%0d exp=1020", cyc + 1); end
      n_total++; if (mole_ytop !== 10'd767) begin n_bad++; $display("FAIL happy_end_ytop got=%0d exp=767", mole_ytop); end
      n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL happy_end_busy got=%0d exp=0", busy); end
   endtask

   task automatic test_hit();
      int cyc;
      bit ok, sh, sm, any_hit;
      spawn(3'd6);
      wait_up(1100, ok);
      n_total++; if (!ok) begin n_bad++; $display("FAIL hit_wait_up got=timeout exp=UP"); end
      any_hit = 0;
      stomp = 1'b1; stomp_loc = 3'd2;
      for (int i = 0; i < 5; i++) begin
         step();
         if (hit_pulse) any_hit = 1;
      end
      stomp = 1'b0;
      n_total++; if (any_hit || sprite_sel !== 2'd1) begin n_bad++; $display("FAIL wrong_hole_stomp hit=%0d sel=%0d exp hit=0 sel=1", any_hit, sprite_sel); end
      repeat (26) step();
      stomp = 1'b1; stomp_loc = 3'd6;
      step();
      n_total++; if (hit_pulse !== 1'b1) begin n_bad++; $display("FAIL hit_vs_expiry_hit got=%0d exp=1", hit_pulse); end
      n_total++; if (miss_pulse !== 1'b0) begin n_bad++; $display("FAIL hit_vs_expiry_miss got=%0d exp=0", miss_pulse); end
      n_total++; if (sprite_sel !== 2'd3) begin n_bad++; $display("FAIL hit_sel got=%0d exp=3", sprite_sel); end
      step();
      stomp = 1'b0;
      n_total++; if (hit_pulse !== 1'b0 || sprite_sel !== 2'd3) begin n_bad++; $display("FAIL hit_width hit=%0d sel=%0d exp hit=0 sel=3", hit_pulse, sprite_sel); end
      wait_sel(2'd0, 1100, cyc, ok, sh, sm);
      n_total++; if (!ok || sh || sm) begin n_bad++; $display("FAIL dead_descent ok=%0d hit=%0d miss=%0d exp 1/0/0", ok, sh, sm); end
      n_total++; if (mole_ytop !== 10'd767) begin n_bad++; $display("FAIL dead_end_ytop got=%0d exp=767", mole_ytop); end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  locs [5];
      logic [10:0] ex   [5];
      logic [9:0]  ey   [5];
      int cyc;
      bit ok, sh, sm, ready_bad;
      locs = '{3'd0, 3'd3, 3'd4, 3'd7, 3'd1};
      ex   = '{11'd65, 11'd65, 11'd747, 11'd747, 11'd406};
      ey   = '{10'd0, 10'd256, 10'd256, 10'd512, 10'd0};
      ready_bad = 0;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_loc = locs[i];
         if (req_ready !== 1'b1) ready_bad = 1;
         step();
      end
      n_total++; if (ready_bad) begin n_bad++; $display("FAIL b2b_ready_during_push got=0 exp=1"); end
      req_loc = 3'd2;
      n_total++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_full_ready got=%0d exp=0", req_ready); end
      ready_bad = 0;
      repeat (3) begin
         step();
         if (req_ready !== 1'b0) ready_bad = 1;
      end
      req_valid = 1'b0;
      n_total++; if (ready_bad) begin n_bad++; $display("FAIL b2b_held_off got=1 exp=0"); end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            step();
            n_total++; if (sprite_sel !== 2'd1) begin n_bad++; $display("FAIL b2b_gap mole=%0d sel=%0d exp=1", i, sprite_sel); end
            n_total++; if (mole_ytop !== ey[i] + 10'd255) begin n_bad++; $display("FAIL b2b_ytop mole=%0d got=%0d exp=%0d", i, mole_ytop, ey[i] + 10'd255); end
         end
         n_total++; if (mole_x !== ex[i] || mole_ybase !== ey[i]) begin n_bad++; $display("FAIL b2b_order mole=%0d got=%0d/%0d exp=%0d/%0d", i, mole_x, mole_ybase, ex[i], ey[i]); end
         wait_sel(2'd0, 2200, cyc, ok, sh, sm);
         n_total++; if (!ok) begin n_bad++; $display("FAIL b2b_idle_timeout mole=%0d got=timeout exp=idle", i); end
      end
      step();
      n_total++; if (busy !== 1'b0 || sprite_sel !== 2'd0) begin n_bad++; $display("FAIL b2b_drained busy=%0d sel=%0d exp 0/0", busy, sprite_sel); end
   endtask

   task automatic test_reset_mid();
      bit ok, stray;
      req_valid = 1'b1; req_loc = 3'd5; step();
      req_loc = 3'd2; step();
      req_loc = 3'd3; step();
      req_valid = 1'b0;
      wait_up(1100, ok);
      n_total++; if (!ok || mole_x !== 11'd65 || mole_ybase !== 10'd512) begin n_bad++; $display("FAIL rmid_up ok=%0d x=%0d yb=%0d exp 1/65/512", ok, mole_x, mole_ybase); end
      stomp = 1'b1; stomp_loc = 3'd5; step(); stomp = 1'b0;
      n_total++; if (hit_pulse !== 1'b1 || sprite_sel !== 2'd3) begin n_bad++; $display("FAIL rmid_hit hit=%0d sel=%0d exp 1/3", hit_pulse, sprite_sel); end
      repeat (10) step();
      reset = 1'b1; step();
      n_total++; if (req_ready !== 1'b1 || sprite_sel !== 2'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_ctrl ready=%0d sel=%0d busy=%0d exp 1/0/0", req_ready, sprite_sel, busy); end
      n_total++; if ({hit_pulse, miss_pulse} !== 2'b00) begin n_bad++; $display("FAIL rmid_pulses got=%b exp=00", {hit_pulse, miss_pulse}); end
      n_total++; if (mole_x !== 11'd65 || mole_ybase !== 10'd0 || mole_ytop !== 10'd255) begin n_bad++; $display("FAIL rmid_pos got=%0d/%0d/%0d exp=65/0/255", mole_x, mole_ybase, mole_ytop); end
      reset = 1'b0;
      stray = 0;
      repeat (6) begin
         step();
         if (busy || sprite_sel != 2'd0 || hit_pulse || miss_pulse) stray = 1;
      end
      n_total++; if (stray) begin n_bad++; $display("FAIL rmid_queue_discarded got=activity exp=idle"); end
   endtask

   task automatic test_ascent_stomp();
      int cyc;
      bit ok, sh, sm;
      spawn(3'd6);
      step();
      cyc = 0;
      while (mole_ytop != 10'd700 && cyc < 400) begin step(); cyc++; end
      n_total++; if (mole_ytop !== 10'd700) begin n_bad++; $display("FAIL asc_reach got=%0d exp=700", mole_ytop); end
      stomp = 1'b1; stomp_loc = 3'd6; step(); stomp = 1'b0;
`ifdef MOLE_STOMP_IN_ASCENT_EN
      n_total++; if (hit_pulse !== 1'b1 || sprite_sel !== 2'd3) begin n_bad++; $display("FAIL asc_stomp hit=%0d sel=%0d exp 1/3", hit_pulse, sprite_sel); end
      n_total++; if (mole_ytop !== 10'd700) begin n_bad++; $display("FAIL asc_stomp_ytop got=%0d exp=700", mole_ytop); end
      wait_sel(2'd0, 400, cyc, ok, sh, sm);
      n_total++; if (!ok || sm) begin n_bad++; $display("FAIL asc_desc ok=%0d miss=%0d exp 1/0", ok, sm); end
`else
      n_total++; if (hit_pulse !== 1'b0 || sprite_sel !== 2'd1) begin n_bad++; $display("FAIL asc_stomp_ignored hit=%0d sel=%0d exp 0/1", hit_pulse, sprite_sel); end
      wait_sel(2'd0, 2200, cyc, ok, sh, sm);
      n_total++; if (!ok || sh || !sm) begin n_bad++; $display("FAIL asc_full_cycle ok=%0d hit=%0d miss=%0d exp 1/0/1", ok, sh, sm); end
`endif
      n_total++; if (mole_ytop !== 10'd767) begin n_bad++; $display("FAIL asc_end_ytop got=%0d exp=767", mole_ytop); end
   endtask

   initial begin
      n_total = 0;
      n_bad   = 0;
      test_reset();
      test_spawn();
      test_miss();
      test_hit();
      test_back_to_back();
      test_reset_mid();
      test_ascent_stomp();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mole_anim_sequencer.md
# mole_anim_sequencer

Sequences the single mole-sprite renderer through its full per-mole life cycle: spawn, ascent, hold, whack/miss, descent. Mole requests from the game FSM are queued in a small FIFO and issued one at a time. For the active mole the block drives sprite position and selection to the display path, and reports hit or miss outcomes back to the game FSM as single-cycle pulses. It runs in the `vclock` pixel domain alongside `xvga`.

## Interface
Parameters:
- `STEP_DIV`, 33750 — `vclock` cycles per animation step tick.
- `SPRITE_H`, 256 — sprite height in lines; ascent/descent travel is `SPRITE_H-1` steps.
- `UP_TICKS`, 1024 — step ticks a fully raised mole stays up before being missed.
- `FIFO_DEPTH`, 4 — request queue depth; power of two.

Ports:
- `vclock` in 1 — pixel clock.
- `reset` in 1 — synchronous, active-high.
- `req_valid` in 1 — spawn request.
- `req_loc` in 3 — hole index 0..7.
- `req_ready` out 1 — FIFO not full.
- `stomp` in 1 — stomp event, level-sampled each cycle.
- `stomp_loc` in 3 — hole stomped.
- `mole_x` out 11 — sprite left x.
- `mole_ybase` out 10 — hole top y (fixed per hole).
- `mole_ytop` out 10 — current sprite top, `mole_ybase + offset`.
- `sprite_sel` out 2 — 0 none, 1 normal, 2 happy, 3 dead.
- `hit_pulse` out 1 — one cycle on whack.
- `miss_pulse` out 1 — one cycle on expiry.
- `busy` out 1 — state ≠ IDLE or FIFO non-empty.

## Operation
- Hole table, x/ybase:
  - 0 = 65/0, 1 = 406/0, 2 = 747/0
  - 3 = 65/256, 4 = 747/256
  - 5 = 65/512, 6 = 406/512, 7 = 747/512
- Step tick: free-running counter 0..`STEP_DIV-1`. Tick is asserted the cycle the counter equals `STEP_DIV-1`, and the counter wraps to 0 on that cycle.
- States:
  - IDLE: `sprite_sel`=0. If the FIFO is non-empty, pop it, load x/ybase from the table, set offset=`SPRITE_H-1`, go to ASCEND.
  - ASCEND: `sprite_sel`=1. On tick, offset−1. If the new offset is 0, go to UP (same edge) and clear the hold counter.
  - UP: `sprite_sel`=1. Stomp with `stomp_loc` equal to the active hole → `hit_pulse`, go to DESC_DEAD. Otherwise, on tick, hold count+1; on the tick where the count equals `UP_TICKS-1` → `miss_pulse`, go to DESC_HAPPY.
  - DESC_DEAD / DESC_HAPPY: `sprite_sel` is 3 / 2 respectively. On tick, offset+1. If the new offset is `SPRITE_H-1`, go to IDLE (same edge). Stomps are ignored.
- Stomp and expiry tick in the same UP cycle: stomp wins, giving a hit and no miss.
- Stomp at a non-matching hole: ignored.
- FIFO:
  - Push when `req_valid & req_ready`.
  - `req_ready = ~full`, registered from the count.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Offset arithmetic: 9-bit unsigned, never leaves [0, `SPRITE_H-1`]. `mole_ytop` is a 10-bit add with no overflow for the table values.

## Timing
- Reset values:
  - `req_ready`=1, `sprite_sel`=0, `hit_pulse`=0, `miss_pulse`=0, `busy`=0
  - `mole_x`=65, `mole_ybase`=0, `mole_ytop`=255
  - FIFO empty, step counter 0, state IDLE.
- Reset mid-operation aborts the mole with no pulse and discards all queued requests.
- Spawn latency, request accepted at edge N with the machine idle and the FIFO empty:
  - FIFO non-empty after edge N.
  - ASCEND, with x/ybase/`mole_ytop` valid, after edge N+1.
- Phase durations:
  - Ascent: `SPRITE_H-1` ticks.
  - Hold: `UP_TICKS` ticks.
  - Descent: `SPRITE_H-1` ticks.
  - The first tick of each phase falls within ≤`STEP_DIV` cycles.
- Pulses assert on the edge that enters DESC_*, for exactly one cycle.
- Back-to-back moles: the next pop occurs one cycle after entering IDLE.

## Configuration
- `MOLE_STOMP_IN_ASCENT_EN` defined: a matching stomp during ASCEND also whacks. `hit_pulse` fires and the state goes to DESC_DEAD; descent starts from the current offset.
- Undefined: stomps during ASCEND are ignored.

## Structure
- Shared package `mole_pkg` holds:
  - state enum (IDLE, ASCEND, UP, DESC_DEAD, DESC_HAPPY);
  - sprite-select codes;
  - hole x/ybase constant tables.
- One sub-module, `mole_req_fifo`: a synchronous FIFO of 3-bit entries, with push/pop/full/empty/count.

## Test plan
Bench parameters: `STEP_DIV`=4, `UP_TICKS`=8, `SPRITE_H`=256.
1. Request loc 6 while idle → ASCEND two edges later with x=406, ybase=512, ytop=767. ytop reaches 512 after 255 ticks; UP is entered.
2. No stomp in UP → after 8 ticks, one `miss_pulse` and `sprite_sel`=2. After 255 more ticks, IDLE and `sprite_sel`=0.
3. Stomp loc 6 in UP → one `hit_pulse` and `sprite_sel`=3. Stomp loc 2 instead → no effect.
4. Push 5 requests back-to-back from idle → 1 pops immediately, 4 fill the FIFO, `req_ready`=0, and the 6th is held off. Moles are issued in push order.
5. Assert reset during DESC_DEAD with 2 queued → all outputs at reset values next cycle, no pulses, `busy`=0.
6. Stomp during ASCEND → hit only when built with `MOLE_STOMP_IN_ASCENT_EN`; otherwise ignored.
